// File: rtl/piso_framer_pkg.sv
// Shared types and constants for the parallel-to-serial framer.
package piso_framer_pkg;

  // Framer state: IDLE waits for a word, SHIFT emits data bits,
  // PARITY emits the optional parity bit, GAP holds the line idle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } piso_state_t;

  // Parity mode selectors for the ODD_PARITY parameter.
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/piso_framer.sv
// Parallel-to-serial framer: captures a word on a valid/ready handshake and
// emits it one bit per clock, optionally followed by a parity bit and then a
// fixed idle gap. All outputs except in_ready are registered.
module piso_framer
  import piso_framer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = PAR_EVEN,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  // Gap counter is at least one bit wide so GAP_CYCLES=0 still elaborates.
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit ODD = (ODD_PARITY == PAR_ODD);

  piso_state_t      state_q;
  piso_state_t      tail_state;
  logic [WIDTH-1:0] shreg_q;
  logic             parity_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic             serial_out_q;
  logic             bit_valid_q;
  logic             frame_start_q;
  logic             busy_q;

  // Bit that leaves the word first, depending on the bit order.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Word after one bit has been sent: move the next bit to the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // State entered once the last bit of a frame has gone out.
  assign tail_state = (GAP_CYCLES > 0) ? GAP : IDLE;

  // Handshake: only in IDLE and never while reset is asserted.
  assign in_ready = (state_q == IDLE) & ~rst;

  // Framer FSM with registered outputs; each register holds what the
  // line shows in the cycle after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      parity_q      <= 1'b0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      serial_out_q  <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is implied here (IDLE and reset low).
          if (in_valid) begin
            serial_out_q  <= head(in_data);
            shreg_q       <= advance(in_data);
            parity_q      <= (^in_data) ^ ODD;
            bit_cnt_q     <= '0;
            bit_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= SHIFT;
          end
        end
        SHIFT: begin
          frame_start_q <= 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (PARITY_EN != 0) begin
              serial_out_q <= parity_q;
              bit_valid_q  <= 1'b1;
              state_q      <= PARITY;
            end else begin
              serial_out_q <= 1'b0;
              bit_valid_q  <= 1'b0;
              gap_cnt_q    <= '0;
              busy_q       <= (GAP_CYCLES > 0);
              state_q      <= tail_state;
            end
          end else begin
            bit_cnt_q    <= bit_cnt_q + 1'b1;
            serial_out_q <= head(shreg_q);
            shreg_q      <= advance(shreg_q);
          end
        end
        PARITY: begin
          serial_out_q <= 1'b0;
          bit_valid_q  <= 1'b0;
          gap_cnt_q    <= '0;
          busy_q       <= (GAP_CYCLES > 0);
          state_q      <= tail_state;
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out  = serial_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_framer.sv
// Bench for piso_framer: three configurations run side by side, each checked
// every cycle against a queue-based frame model, plus literal stream checks.
module tb_piso_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check1(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%b required=%b t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h required=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gi 0: defaults; gi 1: LSB first, odd parity; gi 2: no parity, no gap
  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int MSBF = (gi == 1) ? 0 : 1;
    localparam int PEN  = (gi == 2) ? 0 : 1;
    localparam int ODDP = (gi == 1) ? 1 : 0;
    localparam int GAPC = (gi == 2) ? 0 : 2;
    // Hand-computed expectations
    localparam int PER  = (gi == 2) ? 9 : 12;
    localparam int LOW  = (gi == 2) ? 1 : 3;
    localparam int L1   = (gi == 2) ? 8 : 9;
    localparam int L2   = (gi == 2) ? 16 : 18;
    localparam logic [31:0] W1 = (gi == 0) ? 32'hA5 : (gi == 1) ? 32'h01 : 32'h55;
    localparam logic [31:0] S1 = (gi == 0) ? 32'b101001010 :
                                 (gi == 1) ? 32'b100000000 : 32'b01010101;
    localparam logic [31:0] S2 = (gi == 0) ? 32'b111111110_001111000 :
                                 (gi == 1) ? 32'b111111111_001111001 : 32'b11111111_00111100;
    localparam logic [31:0] S3 = (gi == 0) ? 32'b100000010 :
                                 (gi == 1) ? 32'b100000011 : 32'b10000001;

    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       serial_out;
    logic       bit_valid;
    logic       frame_start;
    logic       busy;
    bit         done = 1'b0;

    piso_framer #(
      .WIDTH(8), .MSB_FIRST(MSBF), .PARITY_EN(PEN), .ODD_PARITY(ODDP), .GAP_CYCLES(GAPC)
    ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .serial_out(serial_out), .bit_valid(bit_valid), .frame_start(frame_start), .busy(busy)
    );

    // Model: an accepted word becomes a list of per-cycle expectations
    // {busy, frame_start, bit_valid, serial_out}; empty list means idle.
    logic [3:0] q[$];
    logic [3:0] cur   = 4'b0000;
    bit         armed = 1'b0;
    always @(negedge clk) begin
      logic [7:0] d;
      logic       b;
      if (armed) begin
        check1("serial_out", gi, serial_out, cur[0]);
        check1("bit_valid", gi, bit_valid, cur[1]);
        check1("frame_start", gi, frame_start, cur[2]);
        check1("busy", gi, busy, cur[3]);
        check1("in_ready", gi, in_ready, !cur[3] && !rst);
      end
      if (rst) begin
        armed = 1'b1;
        q.delete();
        cur = 4'b0000;
      end else if (armed) begin
        if (in_valid && !cur[3]) begin
          d = in_data;
          $display("inst %0d accept data=%02h t=%0t", gi, d, $time);
          for (int i = 0; i < 8; i++) begin
            b = (MSBF != 0) ? d[7-i] : d[i];
            q.push_back({1'b1, (i == 0), 1'b1, b});
          end
          if (PEN != 0) q.push_back({3'b101, (ODDP != 0) ? ~^d : ^d});
          for (int i = 0; i < GAPC; i++) q.push_back(4'b1000);
        end
        cur = (q.size() > 0) ? q.pop_front() : 4'b0000;
      end
    end

    // Capture of the serial stream as the downstream shift stage sees it.
    logic [63:0] capv = '0;
    int          capn = 0;
    time         last_fs = 0;
    time         prev_fs = 0;
    int          lowcnt = 0;
    int          last_low = 0;
    always @(negedge clk) begin
      if (bit_valid === 1'b1) begin
        capv = {capv[62:0], serial_out};
        capn++;
        if (lowcnt > 0) last_low = lowcnt;
        lowcnt = 0;
      end else begin
        lowcnt++;
      end
      if (frame_start === 1'b1) begin
        prev_fs = last_fs;
        last_fs = $time;
      end
    end

    task automatic wait_ready(input string what);
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s inst=%0d in_ready got=%b required=1 within 64 cycles", what, gi, in_ready);
      end
    endtask

    task automatic send(input logic [7:0] dv, input bit hold, output time t);
      in_valid = 1'b1;
      in_data  = dv;
      wait_ready("accept");
      @(posedge clk);
      t = $time;
      #1;
      if (!hold) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    endtask

    task automatic stream_check(input string name, input int base, input int len, input logic [31:0] exp);
      wait_ready(name);
      check32({name, "_len"}, gi, 32'(capn - base), 32'(len));
      check32(name, gi, capv[31:0] & ((32'd1 << len) - 32'd1), exp);
    endtask

    initial begin
      time t0, t1, t2;
      int  base;
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      // Reset held for two edges
      step();
      @(negedge clk);
      check1("rst_in_ready", gi, in_ready, 1'b0);
      check1("rst_busy", gi, busy, 1'b0);
      check1("rst_bit_valid", gi, bit_valid, 1'b0);
      check1("rst_serial", gi, serial_out, 1'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check1("release_in_ready", gi, in_ready, 1'b1);

      // Single directed word
      step();
      base = capn;
      send(W1[7:0], 1'b0, t0);
      stream_check("word1", base, L1, S1);
      check32("fs_pos", gi, 32'(last_fs - t0), 32'd5);

      // Back-to-back with in_valid held high
      step();
      base = capn;
      send(8'hFF, 1'b1, t1);
      send(8'h3C, 1'b0, t2);
      check32("b2b_period", gi, 32'((t2 - t1) / 10), 32'(PER));
      stream_check("b2b_stream", base, L2, S2);

      // Reset during the 4th data bit, then a clean word
      step();
      send(8'hF0, 1'b0, t0);
      repeat (3) step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check1("abort_serial", gi, serial_out, 1'b0);
      check1("abort_bit_valid", gi, bit_valid, 1'b0);
      check1("abort_busy", gi, busy, 1'b0);
      step();
      rst = 1'b0;
      base = capn;
      send(8'h81, 1'b0, t0);
      stream_check("after_abort", base, L1, S3);

      // Continuous 8'h55 words
      step();
      send(8'h55, 1'b1, t0);
      send(8'h55, 1'b1, t1);
      send(8'h55, 1'b0, t2);
      wait_ready("cont");
      check32("cont_accept_period", gi, 32'((t2 - t1) / 10), 32'(PER));
      check32("cont_fs_period", gi, 32'((last_fs - prev_fs) / 10), 32'(PER));
      check32("cont_low_run", gi, 32'(last_low), 32'(LOW));

      // Randomized traffic with occasional resets
      step();
      repeat (400) begin
        rst      = ($urandom_range(0, 39) == 0);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        step();
      end
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (20) step();
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g[0].done && g[1].done && g[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(g[0].done && g[1].done && g[2].done)) begin
      failures++;
      $display("FAIL timeout got=%0d cycles required=completion", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_framer.md
# piso_framer

Upstream parallel-to-serial stage that feeds the serial shift register (`shift_siso`). It accepts a parallel word over a valid/ready handshake, captures it, and emits it one bit per clock on `serial_out`. Each frame is optionally followed by a parity bit, then a fixed idle gap. A per-bit strobe and a frame-start marker are provided so the downstream shift stage and its checker can align to word boundaries.

## Interface
- `WIDTH`, default 8: data word width (≥2).
- `MSB_FIRST`, default 1: 1 = send bit WIDTH-1 first; 0 = send bit 0 first.
- `PARITY_EN`, default 1: 1 = append one parity bit after the data bits.
- `ODD_PARITY`, default 0: 0 = even parity (bit = ^data); 1 = odd parity (bit = ~^data).
- `GAP_CYCLES`, default 2: idle cycles after each frame (0 allowed).

One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  parallel word; sampled only on accept.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `serial_out`  out  1  serial bit stream into `shift_siso.serial_in`.
- `bit_valid`  out  1  `serial_out` carries a data or parity bit this cycle.
- `frame_start`  out  1  high only on the cycle carrying the first data bit.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE → SHIFT on accept (`in_valid & in_ready`).
  - SHIFT → PARITY after WIDTH bits if `PARITY_EN`, else → GAP.
  - PARITY → GAP.
  - GAP → IDLE after GAP_CYCLES cycles.
  - With `GAP_CYCLES=0`, GAP is skipped: transition goes straight to IDLE.
- `in_ready = (state==IDLE) & ~rst`. Combinational, no dependence on `in_valid`.
- On accept:
  - Capture `in_data` into a WIDTH-bit shift register.
  - Compute and register the parity bit from the captured word.
  - Later changes on `in_data` have no effect.
- SHIFT:
  - `serial_out` = current head bit; the register shifts by one per cycle toward the output end.
  - A bit counter of width $clog2(WIDTH+1) counts 0..WIDTH-1.
  - `bit_valid=1` throughout.
- PARITY: `serial_out` = parity bit, `bit_valid=1`.
- IDLE/GAP: `serial_out=0`, `bit_valid=0`, `frame_start=0`.
- All outputs except `in_ready` are registered.

## Timing
- Reset values (cycle after the `rst` edge): state IDLE, `serial_out=0`, `bit_valid=0`, `frame_start=0`, `busy=0`, counters 0. `in_ready=0` while `rst` is high.
- Reset mid-frame: the frame is aborted with no partial continuation. The next word is accepted no earlier than the first cycle with `rst` low.
- Accept at edge k:
  - First data bit on `serial_out` from edge k+1 (`frame_start=1` that cycle only).
  - Data bits occupy cycles k+1..k+WIDTH.
  - Parity bit at k+WIDTH+1.
  - Gap follows; IDLE with `in_ready=1` after the gap.
- Frame period is 1+WIDTH+PARITY_EN+GAP_CYCLES cycles. Defaults give 12.
- `in_valid` held high continuously: words are accepted back-to-back at that period, with none dropped or duplicated.
- `in_valid` while busy: ignored, and the word is not consumed. The source must hold it until `in_ready`.

## Structure
- Shared package `piso_framer_pkg`:
  - state enum typedef `piso_state_t` (IDLE, SHIFT, PARITY, GAP);
  - parity-mode constants `PAR_EVEN=0`, `PAR_ODD=1`.
- Single module, no sub-module. Shift register, bit counter and gap counter are inline.

## Test plan
All scenarios use defaults unless stated; a scoreboard captures `shift_siso` output in every scenario.
1. Reset: hold `rst` 2 cycles.
   → `serial_out=0`, `bit_valid=0`, `busy=0`, `in_ready=0` during reset; `in_ready=1` the first cycle after release.
2. Accept 8'hA5.
   → `serial_out` = 1,0,1,0,0,1,0,1 on cycles k+1..k+8 with `frame_start` only at k+1, parity 0 at k+9, two gap cycles of 0, `in_ready` back at k+12.
3. `MSB_FIRST=0`, `ODD_PARITY=1`, accept 8'h01.
   → bits 1,0,0,0,0,0,0,0, then parity 0.
4. `in_valid` held high with 8'hFF then 8'h3C.
   → second accept exactly 12 cycles after the first; streams 11111111,0 then 00111100,0.
5. Assert `rst` at the 4th data bit of 8'hF0.
   → next cycle `serial_out=0`, `bit_valid=0`, state IDLE; a new word 8'h81 sent intact after release.
6. `PARITY_EN=0`, `GAP_CYCLES=0`, continuous 8'h55 words.
   → period 9 cycles, `bit_valid` low exactly one cycle between frames.
